mmio_irq_ctrl: RTL and testbench

- Game Boy interrupt controller. Holds IF (0xFF0F) and IE (0xFFFF).
- Latches one-cycle request pulses from the timer, PPU, serial and joypad blocks.
- Arbitrates pending interrupts by fixed priority.
- Runs the dispatch handshake with the CPU core: supplies the winning vector and clears the serviced IF bit.

---
 rtl/gb_irq_pkg.sv | 35 +++
 rtl/mem_if.sv | 21 ++
 rtl/irq_prio_enc.sv | 23 ++
 rtl/mmio_irq_ctrl.sv | 151 +++++++++++++++
 tb/tb_mmio_irq_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_irq_pkg.sv
// Shared constants and types for the Game Boy interrupt controller.
// Source indices, MMIO addresses, vector table and the dispatch FSM type.
package gb_irq_pkg;

   localparam int unsigned IRQ_VBLANK   = 0;
   localparam int unsigned IRQ_LCD_STAT = 1;
   localparam int unsigned IRQ_TIMER    = 2;
   localparam int unsigned IRQ_SERIAL   = 3;
   localparam int unsigned IRQ_JOYPAD   = 4;

   localparam int unsigned IDX_W = 3;

   localparam logic [15:0] ADDR_IF = 16'hFF0F;
   localparam logic [15:0] ADDR_IE = 16'hFFFF;

   localparam logic [7:0] RD_UNMAPPED = 8'haa;

   localparam logic [15:0] VEC_VBLANK   = 16'h0040;
   localparam logic [15:0] VEC_LCD_STAT = 16'h0048;
   localparam logic [15:0] VEC_TIMER    = 16'h0050;
   localparam logic [15:0] VEC_SERIAL   = 16'h0058;
   localparam logic [15:0] VEC_JOYPAD   = 16'h0060;

   typedef enum logic {
      IDLE,
      DISPATCH
   } irq_fsm_t;

   function automatic logic [15:0] irq_vector_of(input logic [15:0]    base,
                                                 input int unsigned    stride,
                                                 input logic [IDX_W-1:0] idx);
      return base + 16'(stride) * 16'(idx);
   endfunction

endpackage

// File: rtl/mem_if.sv
// Byte-wide MMIO bus: the CPU side drives address/write, the peripheral returns read data.
interface mem_if;
   logic [15:0] addr_select;
   logic        write_enable;
   logic [7:0]  write_value;
   logic [7:0]  read_out;

   modport slave (
      input  addr_select,
      input  write_enable,
      input  write_value,
      output read_out
   );

   modport master (
      output addr_select,
      output write_enable,
      output write_value,
      input  read_out
   );
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest set bit of mask wins.
module irq_prio_enc #(
   parameter int unsigned NUM   = 5,
   parameter int unsigned IDX_W = 3
) (
   input  logic [NUM-1:0]   mask,
   output logic [IDX_W-1:0] index,
   output logic             any_valid
);

   // Scan high to low so the lowest set index is the last assignment.
   always_comb begin
      index     = '0;
      any_valid = 1'b0;
      for (int i = NUM - 1; i >= 0; i--) begin
         if (mask[i]) begin
            index     = IDX_W'(i);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mmio_irq_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, request latching, fixed-priority
// arbitration and the two-cycle dispatch handshake with the CPU.
module mmio_irq_ctrl #(
   parameter int unsigned NUM_IRQ       = 5,
   parameter logic [15:0] VECTOR_BASE   = 16'h0040,
   parameter int unsigned VECTOR_STRIDE = 8
) (
   input  logic               clk,
   input  logic               rst,
   mem_if.slave               req,
   input  logic [NUM_IRQ-1:0] irq_req,
   input  logic               cpu_irq_ack,
   output logic               irq_pending,
   output logic               wake,
   output logic [15:0]        irq_vector,
   output logic               irq_vector_valid,
   output logic [2:0]         irq_index
);

   import gb_irq_pkg::*;

   logic [NUM_IRQ-1:0] if_q, if_d;
   logic [7:0]         ie_q, ie_d;
   logic [1:0]         if_cnt_q, if_cnt_d;
   logic [1:0]         ie_cnt_q, ie_cnt_d;
   logic               if_sel, ie_sel;
   logic               if_commit, ie_commit;

   irq_fsm_t           state_q, state_d;
   logic               cap_any_q, cap_any_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [15:0]        vec_q, vec_d;

   logic [NUM_IRQ-1:0] active;
   logic [IDX_W-1:0]   win_idx;
   logic               win_any;
   logic [7:0]         rd_if;

   assign active = if_q & ie_q[NUM_IRQ-1:0];

   irq_prio_enc #(
      .NUM   (NUM_IRQ),
      .IDX_W (IDX_W)
   ) u_prio (
      .mask      (active),
      .index     (win_idx),
      .any_valid (win_any)
   );

   // Hold counters: 0 = idle, 1 = first cycle seen, 2 = committed (wait for release).
   always_comb begin
      if_sel    = req.write_enable && (req.addr_select == ADDR_IF);
      ie_sel    = req.write_enable && (req.addr_select == ADDR_IE);
      if_commit = if_sel && (if_cnt_q == 2'd1);
      ie_commit = ie_sel && (ie_cnt_q == 2'd1);

      if_cnt_d = 2'd0;
      if (if_sel) begin
         if_cnt_d = (if_cnt_q == 2'd0) ? 2'd1 : 2'd2;
      end
      ie_cnt_d = 2'd0;
      if (ie_sel) begin
         ie_cnt_d = (ie_cnt_q == 2'd0) ? 2'd1 : 2'd2;
      end
   end

   // Precedence on IF: request pulse > MMIO write > dispatch clear.
   always_comb begin
      if_d = if_q;
      if ((state_q == DISPATCH) && cap_any_q) begin
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (idx_q == IDX_W'(i)) begin
               if_d[i] = 1'b0;
            end
         end
      end
      if (if_commit) begin
         if_d = req.write_value[NUM_IRQ-1:0];
      end
      if_d = if_d | irq_req;

      ie_d = ie_q;
      if (ie_commit) begin
         ie_d = req.write_value;
      end
   end

   always_comb begin
      state_d   = state_q;
      cap_any_d = cap_any_q;
      idx_d     = idx_q;
      vec_d     = vec_q;
      unique case (state_q)
         IDLE: begin
            if (cpu_irq_ack) begin
               state_d   = DISPATCH;
               cap_any_d = win_any;
               idx_d     = win_any ? win_idx : '0;
               vec_d     = win_any ? irq_vector_of(VECTOR_BASE, VECTOR_STRIDE, win_idx)
                                   : 16'h0000;
            end
         end
         DISPATCH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if_q      <= '0;
         ie_q      <= '0;
         if_cnt_q  <= '0;
         ie_cnt_q  <= '0;
         state_q   <= IDLE;
         cap_any_q <= 1'b0;
         idx_q     <= '0;
         vec_q     <= '0;
      end else begin
         if_q      <= if_d;
         ie_q      <= ie_d;
         if_cnt_q  <= if_cnt_d;
         ie_cnt_q  <= ie_cnt_d;
         state_q   <= state_d;
         cap_any_q <= cap_any_d;
         idx_q     <= idx_d;
         vec_q     <= vec_d;
      end
   end

   always_comb begin
      rd_if                = 8'hff;
      rd_if[NUM_IRQ-1:0]   = if_q;
      unique case (req.addr_select)
         ADDR_IF: req.read_out = rd_if;
         ADDR_IE: req.read_out = ie_q;
         default: req.read_out = RD_UNMAPPED;
      endcase
   end

   assign irq_pending      = |active;
   assign wake             = irq_pending;
   assign irq_vector       = vec_q;
   assign irq_index        = idx_q;
   // A reset landing on the DISPATCH cycle must suppress the strobe.
   assign irq_vector_valid = (state_q == DISPATCH) && !rst;

endmodule

// File: tb/tb_mmio_irq_ctrl.sv
// Self-checking bench for mmio_irq_ctrl: per-feature tasks plus a dispatch scoreboard.
module tb_mmio_irq_ctrl;
   import gb_irq_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  irq_req = '0;
   logic        cpu_irq_ack = 1'b0;
   logic        irq_pending, wake, irq_vector_valid;
   logic [15:0] irq_vector;
   logic [2:0]  irq_index;

   mem_if bus ();

   int n_checks = 0;
   int n_fails  = 0;

   logic [18:0] exp_q[$];

   mmio_irq_ctrl #(
      .NUM_IRQ       (5),
      .VECTOR_BASE   (16'h0040),
      .VECTOR_STRIDE (8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req              (bus),
      .irq_req          (irq_req),
      .cpu_irq_ack      (cpu_irq_ack),
      .irq_pending      (irq_pending),
      .wake             (wake),
      .irq_vector       (irq_vector),
      .irq_vector_valid (irq_vector_valid),
      .irq_index        (irq_index)
   );

   always #5 clk = ~clk;

   // Scoreboard: every observed strobe must match the oldest expected dispatch.
   always @(negedge clk) begin
      if (irq_vector_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL strobe_unexpected: got vector=%h index=%0d, none expected",
                     irq_vector, irq_index);
         end else begin
            logic [18:0] e;
            e = exp_q.pop_front();
            if ({irq_vector, irq_index} !== e) begin
               n_fails++;
               $display("FAIL strobe_value: got vector=%h index=%0d want vector=%h index=%0d",
                        irq_vector, irq_index, e[18:3], e[2:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] v);
      bus.addr_select = a;
      #1;
      v = bus.read_out;
   endtask

   task automatic mmio_wr(input logic [15:0] a, input logic [7:0] v, input int n);
      bus.addr_select  = a;
      bus.write_value  = v;
      bus.write_enable = 1'b1;
      repeat (n) tick();
      bus.write_enable = 1'b0;
   endtask

   task automatic pulse(input logic [4:0] m);
      irq_req = m;
      tick();
      irq_req = '0;
   endtask

   task automatic do_ack(input logic [15:0] vec, input logic [2:0] idx);
      exp_q.push_back({vec, idx});
      cpu_irq_ack = 1'b1;
      tick();
      cpu_irq_ack = 1'b0;
      tick();
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 8;
      while (exp_q.size() != 0 && budget > 0) begin
         tick();
         budget--;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL %s_drain: %0d strobes outstanding, want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      logic [7:0] v;
      do_reset();
      rd(ADDR_IF, v);
      n_checks++;
      if (v !== 8'he0) begin n_fails++; $display("FAIL reset_if: got %h want e0", v); end
      rd(ADDR_IE, v);
      n_checks++;
      if (v !== 8'h00) begin n_fails++; $display("FAIL reset_ie: got %h want 00", v); end
      rd(16'h1234, v);
      n_checks++;
      if (v !== 8'haa) begin n_fails++; $display("FAIL unmapped_read: got %h want aa", v); end
      n_checks++;
      if ({irq_pending, wake, irq_vector_valid} !== 3'b000 || irq_vector !== 16'h0
          || irq_index !== 3'd0) begin
         n_fails++;
         $display("FAIL reset_outputs: got pend=%b wake=%b valid=%b vec=%h idx=%0d want 0",
                  irq_pending, wake, irq_vector_valid, irq_vector, irq_index);
      end
   endtask

   task automatic test_timer_dispatch();
      logic [7:0] v;
      do_reset();
      mmio_wr(ADDR_IE, 8'h04, 2);
      pulse(5'(1 << IRQ_TIMER));
      n_checks++;
      if (irq_pending !== 1'b1 || wake !== 1'b1) begin
         n_fails++;
         $display("FAIL timer_pending: got pend=%b wake=%b want 1 1", irq_pending, wake);
      end
      tick();
      tick();
      exp_q.push_back({VEC_TIMER, 3'd2});
      cpu_irq_ack = 1'b1;
      tick();
      cpu_irq_ack = 1'b0;
      n_checks++;
      if (irq_vector_valid !== 1'b1) begin
         n_fails++;
         $display("FAIL timer_valid_high: got %b want 1", irq_vector_valid);
      end
      tick();
      n_checks++;
      if (irq_vector_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL timer_valid_one_cycle: got %b want 0", irq_vector_valid);
      end
      n_checks++;
      if (irq_vector !== 16'h0050 || irq_index !== 3'd2) begin
         n_fails++;
         $display("FAIL timer_hold: got vec=%h idx=%0d want 0050 2", irq_vector, irq_index);
      end
      rd(ADDR_IF, v);
      n_checks++;
      if (v !== 8'he0) begin n_fails++; $display("FAIL timer_if_cleared: got %h want e0", v); end
      drain("timer");
   endtask

   task automatic test_priority();
      logic [7:0] v;
      do_reset();
      mmio_wr(ADDR_IE, 8'h1f, 2);
      pulse(5'((1 << IRQ_JOYPAD) | (1 << IRQ_LCD_STAT)));
      do_ack(VEC_LCD_STAT, 3'd1);
      rd(ADDR_IF, v);
      n_checks++;
      if (v !== 8'hf0) begin n_fails++; $display("FAIL prio_if_first: got %h want f0", v); end
      do_ack(VEC_JOYPAD, 3'd4);
      rd(ADDR_IF, v);
      n_checks++;
      if (v !== 8'he0) begin n_fails++; $display("FAIL prio_if_second: got %h want e0", v); end
      drain("prio");
   endtask

   task automatic test_masked();
      logic [7:0] v;
      do_reset();
      pulse(5'(1 << IRQ_VBLANK));
      rd(ADDR_IF, v);
      n_checks++;
      if (v !== 8'he1 || irq_pending !== 1'b0) begin
         n_fails++;
         $display("FAIL masked_latch: got if=%h pend=%b want e1 0", v, irq_pending);
      end
      do_ack(16'h0000, 3'd0);
      rd(ADDR_IF, v);
      n_checks++;
      if (v !== 8'he1) begin n_fails++; $display("FAIL masked_if_kept: got %h want e1", v); end
      drain("masked");
   endtask

   task automatic test_set_beats_clear();
      logic [7:0] v;
      do_reset();
      mmio_wr(ADDR_IE, 8'h04, 2);
      pulse(5'(1 << IRQ_TIMER));
      exp_q.push_back({VEC_TIMER, 3'd2});
      cpu_irq_ack = 1'b1;
      tick();
      cpu_irq_ack = 1'b0;
      pulse(5'(1 << IRQ_TIMER));
      rd(ADDR_IF, v);
      n_checks++;
      if (v !== 8'he4 || irq_pending !== 1'b1) begin
         n_fails++;
         $display("FAIL set_beats_clear: got if=%h pend=%b want e4 1", v, irq_pending);
      end
      drain("set_clear");
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      do_reset();
      mmio_wr(ADDR_IE, 8'h1f, 2);
      pulse(5'((1 << IRQ_VBLANK) | (1 << IRQ_TIMER)));
      // Ack held through DISPATCH: the second cycle must be ignored.
      exp_q.push_back({VEC_VBLANK, 3'd0});
      cpu_irq_ack = 1'b1;
      tick();
      tick();
      cpu_irq_ack = 1'b0;
      tick();
      tick();
      rd(ADDR_IF, v);
      n_checks++;
      if (v !== 8'he4) begin n_fails++; $display("FAIL b2b_if: got %h want e4", v); end
      do_ack(VEC_TIMER, 3'd2);
      drain("b2b");
   endtask

   task automatic test_ie_write_with_ack();
      logic [7:0] v;
      do_reset();
      mmio_wr(ADDR_IE, 8'h01, 2);
      pulse(5'((1 << IRQ_VBLANK) | (1 << IRQ_TIMER)));
      bus.addr_select  = ADDR_IE;
      bus.write_value  = 8'h04;
      bus.write_enable = 1'b1;
      tick();
      exp_q.push_back({VEC_VBLANK, 3'd0});
      cpu_irq_ack = 1'b1;
      tick();
      cpu_irq_ack = 1'b0;
      bus.write_enable = 1'b0;
      tick();
      rd(ADDR_IF, v);
      n_checks++;
      if (v !== 8'he4) begin n_fails++; $display("FAIL ie_ack_if: got %h want e4", v); end
      rd(ADDR_IE, v);
      n_checks++;
      if (v !== 8'h04) begin n_fails++; $display("FAIL ie_ack_ie: got %h want 04", v); end
      drain("ie_ack");
   endtask

   task automatic test_write_beats_clear();
      logic [7:0] v;
      do_reset();
      mmio_wr(ADDR_IE, 8'h02, 2);
      pulse(5'(1 << IRQ_LCD_STAT));
      bus.addr_select  = ADDR_IF;
      bus.write_value  = 8'h02;
      bus.write_enable = 1'b1;
      exp_q.push_back({VEC_LCD_STAT, 3'd1});
      cpu_irq_ack = 1'b1;
      tick();
      cpu_irq_ack = 1'b0;
      tick();
      bus.write_enable = 1'b0;
      tick();
      rd(ADDR_IF, v);
      n_checks++;
      if (v !== 8'he2) begin n_fails++; $display("FAIL write_beats_clear: got %h want e2", v); end
      drain("wr_clear");
   endtask

   task automatic test_if_write_hold();
      logic [7:0] v;
      do_reset();
      pulse(5'(1 << IRQ_LCD_STAT));
      bus.addr_select  = ADDR_IF;
      bus.write_value  = 8'h00;
      bus.write_enable = 1'b1;
      tick();
      irq_req = 5'(1 << IRQ_SERIAL);
      tick();
      irq_req = '0;
      tick();
      bus.write_enable = 1'b0;
      rd(ADDR_IF, v);
      n_checks++;
      if (v !== 8'he8) begin n_fails++; $display("FAIL if_write_hold: got %h want e8", v); end
   endtask

   task automatic test_reset_in_dispatch();
      logic [7:0] v;
      mmio_wr(ADDR_IE, 8'h08, 2);
      cpu_irq_ack = 1'b1;
      tick();
      cpu_irq_ack = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if (irq_vector_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL rst_dispatch_strobe: got %b want 0", irq_vector_valid);
      end
      tick();
      rst = 1'b0;
      rd(ADDR_IF, v);
      n_checks++;
      if (v !== 8'he0) begin n_fails++; $display("FAIL rst_dispatch_if: got %h want e0", v); end
      rd(ADDR_IE, v);
      n_checks++;
      if (v !== 8'h00) begin n_fails++; $display("FAIL rst_dispatch_ie: got %h want 00", v); end
      n_checks++;
      if (irq_vector !== 16'h0 || irq_index !== 3'd0 || irq_pending !== 1'b0) begin
         n_fails++;
         $display("FAIL rst_dispatch_out: got vec=%h idx=%0d pend=%b want 0000 0 0",
                  irq_vector, irq_index, irq_pending);
      end
      tick();
      tick();
      drain("rst_dispatch");
   endtask

   initial begin
      bus.addr_select  = 16'h0000;
      bus.write_enable = 1'b0;
      bus.write_value  = 8'h00;
      test_reset();
      test_timer_dispatch();
      test_priority();
      test_masked();
      test_set_beats_clear();
      test_back_to_back();
      test_ie_write_with_ack();
      test_write_beats_clear();
      test_if_write_hold();
      test_reset_in_dispatch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
